// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared widths and helpers for the on-chip memory arbiter.
// Optional lock feature is selected with ONCHIP_MEMORY_ARBITER_LOCK_EN.
package onchip_memory_arbiter_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // A single-master build still needs a one-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onchip_memory_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_priority_arbiter #(
  parameter int N     = 6,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     request,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  always_comb begin : pick
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter letting NUM_MASTERS Avalon-MM masters share one single-port RAM.
// Define ONCHIP_MEMORY_ARBITER_LOCK_EN to add per-master m_lock bus locking.
module onchip_memory_arbiter
  import onchip_memory_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 6,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BE_W        = be_width(DATA_W)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
`ifdef ONCHIP_MEMORY_ARBITER_LOCK_EN
  input  logic [NUM_MASTERS-1:0]        m_lock,
`endif
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BE_W-1:0]               mem_byteenable,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  input  logic [DATA_W-1:0]             mem_readdata
);

  localparam int PTR_W = ptr_width(NUM_MASTERS);

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [PTR_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] grant_raw;
  logic [NUM_MASTERS-1:0] grant;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       win;
  logic                   granted;
  logic                   win_write;

  logic                   vld_p1;
  logic [PTR_W-1:0]       owner_p1;

  assign request = m_read | m_write;

`ifdef ONCHIP_MEMORY_ARBITER_LOCK_EN
  logic             lock_vld;
  logic [PTR_W-1:0] lock_own;

  assign eligible = lock_vld ? (request & onehot(lock_own)) : request;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_vld <= 1'b0;
    end else if (granted) begin
      lock_vld <= m_lock[win];
      lock_own <= win;
    end else if (lock_vld && !m_lock[lock_own] && !request[lock_own]) begin
      lock_vld <= 1'b0;
    end
  end
`else
  assign eligible = request;
`endif

  rr_priority_arbiter #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr (
    .request (eligible),
    .ptr     (ptr),
    .grant   (grant_raw)
  );

  // Nothing is accepted while reset is held, so no access can leak out of it.
  assign grant   = reset ? '0 : grant_raw;
  assign granted = |grant;

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) win = PTR_W'(i);
    end
  end

  assign win_write = granted & m_write[win];

  assign m_waitrequest  = request & ~grant;
  assign mem_chipselect = granted;
  assign mem_write      = win_write;
  assign mem_address    = m_address[int'(win)*ADDR_W +: ADDR_W];
  assign mem_byteenable = m_byteenable[int'(win)*BE_W +: BE_W];
  assign mem_writedata  = m_writedata[int'(win)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= granted & ~win_write;
      if (granted) ptr <= (win == PTR_W'(NUM_MASTERS-1)) ? '0 : win + 1'b1;
    end
  end

  // Stage p1: RAM read latency, owner travels with vld_p1
  always_ff @(posedge clk) begin
    owner_p1 <= win;
  end

  assign m_readdatavalid = (vld_p1 && !reset) ? onehot(owner_p1) : '0;
  assign m_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Self-checking bench for onchip_memory_arbiter: RAM stub, behavioural model, directed + random traffic.
module tb_onchip_memory_arbiter;

  localparam int N   = 6;
  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int BW  = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    m_read, m_write;
  logic [N-1:0]    m_lock;
  logic [N*AW-1:0] m_address;
  logic [N*BW-1:0] m_byteenable;
  logic [N*DW-1:0] m_writedata;
  logic [N-1:0]    m_waitrequest, m_readdatavalid;
  logic [DW-1:0]   m_readdata;
  logic [AW-1:0]   mem_address;
  logic [BW-1:0]   mem_byteenable;
  logic            mem_chipselect, mem_write;
  logic [DW-1:0]   mem_writedata, mem_readdata;

  onchip_memory_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .m_read          (m_read),
    .m_write         (m_write),
`ifdef ONCHIP_MEMORY_ARBITER_LOCK_EN
    .m_lock          (m_lock),
`endif
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] initv(input int i);
    return 32'(i) * 32'h9E3779B1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // RAM stub: one-cycle registered read, byte-enabled write
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  assign mem_readdata = ram_q;

  initial for (int i = 0; i < (1<<AW); i++) ram[i] = initv(i);

  always @(posedge clk) begin
    if (mem_chipselect === 1'b1) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  // Reference model: round-robin over requesters, expected memory contents, pending read
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            mptr = 0;
  bit            pend_v = 0;
  int            pend_own = 0;
  logic [DW-1:0] pend_data;
  bit            mlock_v = 0;
  int            mlock_own = 0;

  initial begin
    for (int i = 0; i < (1<<AW); i++) shadow[i] = initv(i);
    forever begin
      logic [N-1:0] req, expg, exprv;
      int g, a;
      @(negedge clk);
      req = m_read | m_write;
      g = -1;
      if (!reset) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mptr + k) % N;
          if (g < 0 && req[idx] && (!mlock_v || idx == mlock_own)) g = idx;
        end
      end
      expg = (g >= 0) ? oh(g) : '0;
      chk("waitrequest", m_waitrequest, req & ~expg);
      chk("chipselect", mem_chipselect, g >= 0);
      chk("mem_write", mem_write, (g >= 0) && m_write[g]);
      if (g >= 0) begin
        chk("mem_address", mem_address, m_address[g*AW +: AW]);
        chk("mem_byteenable", mem_byteenable, m_byteenable[g*BW +: BW]);
        if (m_write[g]) chk("mem_writedata", mem_writedata, m_writedata[g*DW +: DW]);
      end
      exprv = (!reset && pend_v) ? oh(pend_own) : '0;
      chk("readdatavalid", m_readdatavalid, exprv);
      if (!reset && pend_v) chk("readdata", m_readdata, pend_data);
      if (reset) begin
        mptr = 0; pend_v = 0; mlock_v = 0;
      end else begin
        pend_v = (g >= 0) && !m_write[g];
        if (g >= 0) begin
          a = int'(m_address[g*AW +: AW]);
          pend_own  = g;
          pend_data = shadow[a];
          if (m_write[g])
            for (int b = 0; b < BW; b++)
              if (m_byteenable[g*BW + b]) shadow[a][b*8 +: 8] = m_writedata[g*DW + b*8 +: 8];
          mptr = (g + 1) % N;
`ifdef ONCHIP_MEMORY_ARBITER_LOCK_EN
          mlock_v = m_lock[g];
          mlock_own = g;
        end else if (mlock_v && !m_lock[mlock_own] && !req[mlock_own]) begin
          mlock_v = 0;
`endif
        end
      end
    end
  end

  // Driver helpers
  logic [N-1:0]  last_grant, last_wait, last_rv;
  logic [DW-1:0] last_rdata;
  logic          last_cs, last_mw;

  task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
    m_read[i]  = rd;
    m_write[i] = wr;
    m_address[i*AW +: AW]    = a;
    m_byteenable[i*BW +: BW] = be;
    m_writedata[i*DW +: DW]  = d;
  endtask

  task automatic step();
    @(negedge clk);
    last_wait  = m_waitrequest;
    last_grant = (m_read | m_write) & ~m_waitrequest;
    last_rv    = m_readdatavalid;
    last_rdata = m_readdata;
    last_cs    = mem_chipselect;
    last_mw    = mem_write;
    @(posedge clk);
    #1;
    m_read  = m_read  & ~last_grant;
    m_write = m_write & ~last_grant;
  endtask

  initial begin
    reset = 1'b1;
    m_read = '0; m_write = '0; m_lock = '0;
    m_address = '0; m_byteenable = '0; m_writedata = '0;
    @(posedge clk); #1;

    // Reset holds everything off
    set_req(0, 1, 0, 13'h010, 4'hF, 0);
    set_req(2, 1, 0, 13'h012, 4'hF, 0);
    step();
    chk("rst_wait", last_wait, 6'h05);
    chk("rst_cs", last_cs, 0);
    chk("rst_rv", last_rv, 0);
    m_read = '0;
    reset = 1'b0;

    // All six read at once
    for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(16 + i), 4'hF, 0);
    for (int i = 0; i < N; i++) begin
      step();
      chk("rr_order", last_grant, oh(i));
      chk("rr_rv", last_rv, (i == 0) ? 6'h00 : oh(i - 1));
    end
    step();
    chk("rr_rv_last", last_rv, 6'h20);
    chk("rr_idle", last_grant, 6'h00);

    // Partial-byte write then read back
    set_req(3, 0, 1, 13'h100, 4'h3, 32'hDEADBEEF);
    step();
    chk("wr_grant", last_grant, 6'h08);
    chk("wr_memwrite", last_mw, 1);
    set_req(1, 1, 0, 13'h100, 4'hF, 0);
    step();
    chk("rd_grant", last_grant, 6'h02);
    step();
    chk("rd_rv", last_rv, 6'b000010);
    chk("rd_beef", last_rdata[15:0], 16'hBEEF);

    // Pointer wrap from 5 to 0
    set_req(4, 0, 1, 13'h120, 4'hF, 32'h12345678);
    step();
    chk("ptr_to5", last_grant, 6'h10);
    set_req(5, 1, 0, 13'h121, 4'hF, 0);
    set_req(0, 1, 0, 13'h122, 4'hF, 0);
    step();
    chk("wrap_first", last_grant, 6'h20);
    step();
    chk("wrap_second", last_grant, 6'h01);
    chk("wrap_rv5", last_rv, 6'h20);
    step();
    chk("wrap_rv0", last_rv, 6'h01);

    // Read+write together behaves as write
    set_req(2, 1, 1, 13'h200, 4'hF, 32'hCAFE0002);
    set_req(4, 1, 1, 13'h204, 4'hF, 32'hCAFE0004);
    step();
    chk("rw_grant2", last_grant, 6'h04);
    chk("rw_mw2", last_mw, 1);
    step();
    chk("rw_grant4", last_grant, 6'h10);
    chk("rw_mw4", last_mw, 1);
    chk("rw_norv1", last_rv, 0);
    step();
    chk("rw_norv2", last_rv, 0);
    set_req(0, 1, 0, 13'h200, 4'hF, 0);
    step();
    chk("rw_rdgrant", last_grant, 6'h01);
    step();
    chk("rw_rdrv", last_rv, 6'h01);
    chk("rw_rddata", last_rdata, 32'hCAFE0002);

    // Reset during a would-be read grant
    set_req(1, 1, 0, 13'h040, 4'hF, 0);
    set_req(0, 1, 0, 13'h041, 4'hF, 0);
    reset = 1'b1;
    step();
    chk("rstrd_wait", last_wait, 6'h03);
    chk("rstrd_rv", last_rv, 0);
    reset = 1'b0;
    step();
    chk("post_rst_grant", last_grant, 6'h01);
    chk("post_rst_rv", last_rv, 0);
    step();
    chk("post_rst_grant1", last_grant, 6'h02);
    chk("post_rst_rv0", last_rv, 6'h01);
    step();
    chk("post_rst_rv1", last_rv, 6'h02);

`ifdef ONCHIP_MEMORY_ARBITER_LOCK_EN
    m_lock[2] = 1'b1;
    set_req(2, 1, 0, 13'h050, 4'hF, 0);
    set_req(0, 1, 0, 13'h051, 4'hF, 0);
    step();
    chk("lock_rd", last_grant, 6'h04);
    set_req(2, 0, 1, 13'h050, 4'hF, 32'h0BADF00D);
    step();
    chk("lock_wr", last_grant, 6'h04);
    chk("lock_wr_wait0", last_wait, 6'h01);
    m_lock[2] = 1'b0;
    step();
    chk("lock_release_wait", last_wait, 6'h01);
    step();
    chk("lock_then_grant0", last_grant, 6'h01);
`endif

    // Random traffic on a small address window to force read-after-write hits
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(m_read[i] | m_write[i]) && $urandom_range(0, 2) == 0) begin
          int kind;
          kind = $urandom_range(0, 3);
          set_req(i, kind != 2, kind >= 2, AW'(13'h300 + $urandom_range(0, 15)),
                  BW'($urandom_range(0, 15)), $urandom);
        end
      end
      reset = (c == 700);
      step();
    end
    reset = 1'b0;

    for (int d = 0; d < 20 && (m_read | m_write) != 0; d++) step();
    chk("drain_idle", m_read | m_write, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onchip_memory_arbiter.md
ONCHIP_MEMORY_ARBITER -- requirements
Module: onchip_memory_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 6, giving the number of Avalon-MM requesters sharing one single-port RAM.
REQ-002 The block SHALL have parameter ADDR_W, default 13, giving the word-address width (8192 words).
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the data width; BE_W = DATA_W/8.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port m_read, input, NUM_MASTERS bits: per-master read request.
REQ-007 The block SHALL have port m_write, input, NUM_MASTERS bits: per-master write request.
REQ-008 The block SHALL have port m_address, input, NUM_MASTERS*ADDR_W bits: packed per-master address, master 0 in the LSBs.
REQ-009 The block SHALL have port m_byteenable, input, NUM_MASTERS*BE_W bits: packed per-master byte enables.
REQ-010 The block SHALL have port m_writedata, input, NUM_MASTERS*DATA_W bits: packed per-master write data.
REQ-011 The block SHALL have port m_waitrequest, output, NUM_MASTERS bits: per-master stall.
REQ-012 The block SHALL have port m_readdatavalid, output, NUM_MASTERS bits: one-hot read-return strobe.
REQ-013 The block SHALL have port m_readdata, output, DATA_W bits: read data broadcast to all masters.
REQ-014 The block SHALL have ports mem_address (ADDR_W), mem_byteenable (BE_W), mem_chipselect (1), mem_write (1) and mem_writedata (DATA_W), all outputs, driving the RAM port.
REQ-015 The block SHALL have port mem_readdata, input, DATA_W bits: RAM output, valid one cycle after a read is presented.

Function
REQ-016 The block SHALL treat master i as requesting when m_read[i] or m_write[i] is high; with both high, the access SHALL be a write and the read SHALL be ignored.
REQ-017 The block SHALL grant at most one requester per cycle, combinationally, by round-robin starting at the master after the last granted one (pointer ptr).
REQ-018 The block SHALL drive m_waitrequest[i] = request[i] & ~grant[i]; the granted access SHALL complete in the same cycle.
REQ-019 The block SHALL drive mem_chipselect = 1, mem_write = 1 for a granted write, 0 for a granted read, and the mem_address, mem_byteenable and mem_writedata of the winner.
REQ-020 With no request, the block SHALL drive mem_chipselect = 0 and mem_write = 0; ptr SHALL hold.
REQ-021 After a grant to master g, ptr SHALL become (g+1) mod NUM_MASTERS, wrapping from NUM_MASTERS-1 to 0.
REQ-022 For a granted read, the block SHALL register the owner; on the next cycle it SHALL assert m_readdatavalid[owner] for exactly one cycle, with m_readdata = mem_readdata.
REQ-023 Back-to-back reads from different masters SHALL return in grant order, one per cycle, with no bubbles.
REQ-024 A granted write SHALL produce no m_readdatavalid.

Reset
REQ-025 While reset is high, the block SHALL set ptr = 0, clear the read-owner valid flag and the lock state, and drive m_readdatavalid = 0, mem_chipselect = 0, mem_write = 0 and m_waitrequest = request.
REQ-026 A read granted in the cycle reset asserts SHALL NOT return m_readdatavalid.

Configuration
REQ-027 With macro ONCHIP_MEMORY_ARBITER_LOCK_EN defined, the block SHALL add input port m_lock (NUM_MASTERS bits).
REQ-028 With the lock option, a grant to master g with m_lock[g] = 1 SHALL make g the lock owner; while a lock owner exists, only the owner SHALL be grantable and all others SHALL wait.
REQ-029 With the lock option, the lock SHALL clear on a granted owner access with m_lock = 0, or on any cycle where the owner has m_lock = 0 and no request.
REQ-030 Without ONCHIP_MEMORY_ARBITER_LOCK_EN, the port and lock logic SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-031 The block SHALL take the ADDR_W/DATA_W defaults and the BE_W derivation from package onchip_memory_arbiter_pkg.
REQ-032 Grant selection SHALL be a combinational sub-module rr_priority_arbiter (inputs: request vector and ptr; output: one-hot grant).

Verification
REQ-033 The bench SHALL check: after reset, masters 0-5 all issue reads on one cycle -> grants in order 0,1,2,3,4,5 on consecutive cycles, each m_readdatavalid exactly one cycle after its grant.
REQ-034 The bench SHALL check: master 3 writes 0xDEADBEEF to 0x0100 with byteenable 0x3, then master 1 reads 0x0100 -> readdata[15:0] = 0xBEEF, m_readdatavalid = 6'b000010.
REQ-035 The bench SHALL check: ptr = 5 and masters 5 and 0 requesting -> 5 is granted first, then 0 (wrap-around).
REQ-036 The bench SHALL check: master 2 and master 4 both assert read and write -> writes only, no readdatavalid.
REQ-037 The bench SHALL check: reset is asserted in the cycle of a granted read from master 1 -> no m_readdatavalid on the next cycle and ptr = 0.
REQ-038 The bench SHALL check (LOCK_EN): master 2 issues a locked read then a locked write while master 0 requests continuously -> master 0 waits until master 2 drops m_lock, then is granted on the next cycle.
